// File: rtl/seq_magnitude_compare.sv
// seq_magnitude_compare: multi-cycle magnitude comparator.
// Operands are captured through a valid/ready handshake and compared MSB-first,
// SLICE bits per cycle. The one-hot gt/eq/lt result is returned through a second
// valid/ready handshake. Unsigned or two's-complement mode is chosen per transaction.
// Optional feature macro: SEQ_CMP_EARLY_EXIT_EN. When it is defined, the block
// finishes on the first differing slice. When it is undefined, every compare
// takes the full N slice steps.
//
// Handshake rules: a transfer happens on a rising edge where valid && ready is
// high. in_ready is high only in IDLE with rst low. out_valid is high only in
// DONE, and the result flags hold steady until out_ready is seen.

module seq_magnitude_compare #(
    parameter int WIDTH = 8,
    parameter int SLICE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int N  = WIDTH / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 2 || (WIDTH % SLICE) != 0) begin : g_bad_params
        $error("seq_magnitude_compare: WIDTH must be >= 2 and divisible by SLICE");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             decided_q, decided_d;
    logic             gt_q, gt_d, lt_q, lt_d;

    logic [WIDTH-1:0] sign_flip;
    logic [SLICE-1:0] a_top, b_top;
    logic             last_slice;
    logic             new_diff;

    // Signed mode inverts the MSB at capture, which turns two's complement
    // into offset binary. The compare itself is then always unsigned.
    assign sign_flip  = {1'b1, {(WIDTH-1){1'b0}}};
    // The operands shift left once per step, so the slice under test is always on top.
    assign a_top      = a_q[WIDTH-1 -: SLICE];
    assign b_top      = b_q[WIDTH-1 -: SLICE];
    assign last_slice = (idx_q == IW'(N - 1));
    assign new_diff   = !decided_q && (a_top != b_top);

    // Next-state logic and datapath updates. Every register holds its value by default.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        gt_d      = gt_q;
        lt_d      = lt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d       = signed_mode ? (a ^ sign_flip) : a;
                    b_d       = signed_mode ? (b ^ sign_flip) : b;
                    idx_d     = '0;
                    decided_d = 1'b0;
                    gt_d      = 1'b0;
                    lt_d      = 1'b0;
                    state_d   = S_COMPARE;
                end
            end
            S_COMPARE: begin
                a_d = a_q << SLICE;
                b_d = b_q << SLICE;
                // Only the first differing slice decides the result. It is frozen after that.
                if (new_diff) begin
                    decided_d = 1'b1;
                    gt_d      = (a_top > b_top);
                    lt_d      = (a_top < b_top);
                end
`ifdef SEQ_CMP_EARLY_EXIT_EN
                if (last_slice || new_diff) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
`else
                if (last_slice) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                if (out_ready) begin
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers. A synchronous reset takes priority over every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
        end
    end

    // The result flags are visible only in DONE. eq is whatever is neither gt nor lt.
    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign gt        = out_valid && gt_q;
    assign lt        = out_valid && lt_q;
    assign eq        = out_valid && !gt_q && !lt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_magnitude_compare.sv
// Testbench for seq_magnitude_compare (WIDTH=8, SLICE=2, N=4).
// A transaction-level reference model predicts the handshake signals and the
// result flags on every cycle. Directed literal expectations pin the model.
// Random transactions cover the remaining operand space.

module tb_seq_magnitude_compare;

    localparam int W  = 8;
    localparam int S  = 2;
    localparam int NS = W / S;
    localparam logic [7:0] SMASK = 8'h03;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a_i = '0;
    logic [7:0] b_i = '0;
    logic       sm = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       gt, eq, lt, busy;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    seq_magnitude_compare #(.WIDTH(W), .SLICE(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a_i), .b(b_i), .signed_mode(sm), .out_valid(out_valid),
        .out_ready(out_ready), .gt(gt), .eq(eq), .lt(lt), .busy(busy),
        .dbg_state(dbg_state)
    );

    // Clock generation.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference result as {gt,eq,lt}, computed with plain integer comparison.
    function automatic logic [2:0] ref_res(input logic [7:0] x, input logic [7:0] y, input logic s);
        int xi, yi;
        xi = s ? int'($signed(x)) : int'(x);
        yi = s ? int'($signed(y)) : int'(y);
        if (xi > yi) return 3'b100;
        if (xi == yi) return 3'b010;
        return 3'b001;
    endfunction

    // Reference latency: number of edges from acceptance until the result is presented.
    function automatic int ref_lat(input logic [7:0] x, input logic [7:0] y);
`ifdef SEQ_CMP_EARLY_EXIT_EN
        logic [7:0] d;
        d = x ^ y;
        for (int k = 0; k < NS; k++) begin
            if (((d >> (W - (k + 1) * S)) & SMASK) != 8'h00) return k + 1;
        end
`endif
        return NS;
    endfunction

    // Transaction-level model: idle, counting down, or holding a result.
    bit         m_busy = 1'b0;
    bit         m_valid = 1'b0;
    int         m_cnt = 0;
    logic [2:0] m_res = 3'b000;

    always @(posedge clk) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_cnt   <= 0;
            m_res   <= 3'b000;
        end else if (!m_busy && in_valid) begin
            m_busy  <= 1'b1;
            m_valid <= 1'b0;
            m_cnt   <= ref_lat(a_i, b_i);
            m_res   <= ref_res(a_i, b_i, sm);
        end else if (m_busy && !m_valid) begin
            if (m_cnt == 1) m_valid <= 1'b1;
            else m_cnt <= m_cnt - 1;
        end else if (m_valid && out_ready) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        check("in_ready", in_ready, !rst && !m_busy);
        check("busy", busy, m_busy);
        check("out_valid", out_valid, m_valid);
        check("flags", {gt, eq, lt}, m_valid ? m_res : 3'b000);
    end

    // Driver. Call it #1 after a rising edge. It returns #1 after the output handshake edge.
    task automatic run_txn(input logic [7:0] x, input logic [7:0] y, input logic s,
                           input int hold, input bit inject,
                           output int lat, output logic [2:0] res);
        int guard;
        int cycles;
        lat = -1;
        res = 3'b000;
        out_ready = 1'b0;
        a_i = x; b_i = y; sm = s; in_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_i = 8'($urandom); b_i = 8'($urandom); sm = 1'($urandom);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (!out_valid) out_ready = 1'($urandom_range(0, 1));
        end while (!out_valid && cycles < 40);
        if (!out_valid) begin
            check("result_timeout", 32'd0, 32'd1);
            out_ready = 1'b0;
            return;
        end
        lat = cycles - 1;
        res = {gt, eq, lt};
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            if (inject) begin
                in_valid = 1'b1;
                a_i = ~x;
                b_i = 8'($urandom);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    int         lat;
    logic [2:0] res;
    logic [7:0] rx, ry;
    logic       rs;

    // Main stimulus sequence.
    initial begin
        // Pin the reference model with hand-computed values.
        check("model_A5_5A", ref_res(8'hA5, 8'h5A, 1'b0), 3'b100);
        check("model_3C_3C", ref_res(8'h3C, 8'h3C, 1'b0), 3'b010);
        check("model_FF_01_s", ref_res(8'hFF, 8'h01, 1'b1), 3'b001);
        check("model_FF_01_u", ref_res(8'hFF, 8'h01, 1'b0), 3'b100);
        check("model_80_7F_s", ref_res(8'h80, 8'h7F, 1'b1), 3'b001);
`ifdef SEQ_CMP_EARLY_EXIT_EN
        check("model_lat_A5", ref_lat(8'hA5, 8'h5A), 1);
`else
        check("model_lat_A5", ref_lat(8'hA5, 8'h5A), 4);
`endif
        check("model_lat_3C", ref_lat(8'h3C, 8'h3C), 4);
        check("model_lat_01", ref_lat(8'h01, 8'h00), 4);

        // Hold reset, then check the reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_flags", {gt, eq, lt}, 3'b000);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed cases.
        run_txn(8'hA5, 8'h5A, 1'b0, 0, 1'b0, lat, res);
        check("A5_5A_res", res, 3'b100);
`ifdef SEQ_CMP_EARLY_EXIT_EN
        check("A5_5A_lat", lat, 1);
`else
        check("A5_5A_lat", lat, 4);
`endif
        run_txn(8'h3C, 8'h3C, 1'b0, 1, 1'b0, lat, res);
        check("3C_eq_res", res, 3'b010);
        check("3C_eq_lat", lat, 4);
        run_txn(8'h01, 8'h00, 1'b0, 0, 1'b0, lat, res);
        check("01_00_res", res, 3'b100);
        check("01_00_lat", lat, 4);
        run_txn(8'hFF, 8'h01, 1'b1, 0, 1'b0, lat, res);
        check("FF_01_signed", res, 3'b001);
        run_txn(8'hFF, 8'h01, 1'b0, 0, 1'b0, lat, res);
        check("FF_01_unsigned", res, 3'b100);
        run_txn(8'h80, 8'h7F, 1'b1, 0, 1'b0, lat, res);
        check("80_7F_signed", res, 3'b001);

        // Back-pressure with a competing in_valid while the result is held.
        run_txn(8'h5A, 8'hA5, 1'b0, 5, 1'b1, lat, res);
        check("bp_res", res, 3'b001);
        @(negedge clk);
        check("bp_in_ready_after", in_ready, 1'b1);
        @(posedge clk); #1;

        // Reset in the middle of a compare.
        a_i = 8'h77; b_i = 8'h11; sm = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        check("abort_accept_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_flags", {gt, eq, lt}, 3'b000);
        @(posedge clk); #1;
        run_txn(8'h10, 8'h20, 1'b0, 0, 1'b0, lat, res);
        check("after_abort_res", res, 3'b001);

        // Back-to-back transactions.
        run_txn(8'hC3, 8'hC3, 1'b1, 0, 1'b0, lat, res);
        check("b2b_first", res, 3'b010);
        run_txn(8'h00, 8'hFF, 1'b1, 0, 1'b0, lat, res);
        check("b2b_second", res, 3'b100);
        run_txn(8'h00, 8'hFF, 1'b0, 0, 1'b0, lat, res);
        check("b2b_third", res, 3'b001);

        // Random transactions.
        for (int t = 0; t < 150; t++) begin
            rx = 8'($urandom);
            ry = ($urandom_range(0, 7) == 0) ? rx : 8'($urandom);
            rs = 1'($urandom);
            run_txn(rx, ry, rs, $urandom_range(0, 3), 1'($urandom), lat, res);
            check("rand_res", res, ref_res(rx, ry, rs));
            check("rand_lat", lat, ref_lat(rx, ry));
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
